// File: rtl/shot_slot_arbiter.sv
// shot_slot_arbiter
// Shared projectile slot pool for the player ship and the alien formation.
// Arbitrates fire requests, allocates the lowest free slot, advances every
// live shot on a movement tick, and retires shots that leave the playfield
// or are reported hit by the collision logic.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   req_player        player fire request (level), spawn X from x_player
//   req_alien         alien fire request (level), spawn at x_alien/y_alien
//   hit_valid/slot    one-cycle pulse retiring slot hit_slot
//   grant_player/alien one-cycle pulse, shot allocated at this edge
//   player_busy       a player shot is live or the cooldown is running
//   pool_full         every slot is live
//   slot_valid/owner  per-slot live flag and owner (1 = player, moves up)
//   slot_x/y_flat     slot i coordinates in bits [11i+10:11i]
module shot_slot_arbiter #(
  parameter int NUM_SLOTS       = 4,
  parameter int PLAYER_COOLDOWN = 40000000,
  parameter int TICK_DIV        = 100000,
  parameter int SHOT_STEP       = 2,
  parameter int Y_TOP           = 10,
  parameter int Y_BOTTOM        = 500,
  parameter int PLAYER_SHOT_Y   = 488,
  parameter int PLAYER_X_OFFSET = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_player,
  input  logic [10:0]             x_player,
  input  logic                    req_alien,
  input  logic [10:0]             x_alien,
  input  logic [10:0]             y_alien,
  input  logic                    hit_valid,
  input  logic [2:0]              hit_slot,
  output logic                    grant_player,
  output logic                    grant_alien,
  output logic                    player_busy,
  output logic                    pool_full,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic [NUM_SLOTS-1:0]    slot_owner,
  output logic [11*NUM_SLOTS-1:0] slot_x_flat,
  output logic [11*NUM_SLOTS-1:0] slot_y_flat
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = (PLAYER_COOLDOWN > 0) ? $clog2(PLAYER_COOLDOWN + 1) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] COOLDOWN_LOAD = CW'(PLAYER_COOLDOWN);
  localparam logic [TW-1:0] TICK_LAST     = TW'(TICK_DIV - 1);
  localparam logic [10:0]   STEP11        = 11'(SHOT_STEP);
  localparam logic [11:0]   STEP12        = 12'(SHOT_STEP);
  localparam logic [11:0]   TOP_LIMIT     = 12'(Y_TOP + SHOT_STEP);
  localparam logic [11:0]   BOTTOM_LIMIT  = 12'(Y_BOTTOM);
  localparam logic [10:0]   PLAYER_Y      = 11'(PLAYER_SHOT_Y);
  localparam logic [10:0]   X_OFFSET      = 11'(PLAYER_X_OFFSET);

  logic [NUM_SLOTS-1:0] valid_q, owner_q, valid_d, owner_d;
  logic [10:0]          x_q [NUM_SLOTS];
  logic [10:0]          y_q [NUM_SLOTS];
  logic [10:0]          x_d [NUM_SLOTS];
  logic [10:0]          y_d [NUM_SLOTS];
  logic [CW-1:0]        cooldown_q;
  logic [TW-1:0]        tick_cnt_q;
  logic                 rr_last_alien_q;
  logic                 grant_player_q, grant_alien_q, pool_full_q;

  logic [IW-1:0]        free_idx;
  logic                 any_free;
  logic                 player_live;
  logic                 player_elig, alien_elig;
  logic                 win_player, win_alien;
  logic                 tick;

  // Lowest-index free slot, searched on pre-edge state so a slot freed this
  // cycle only becomes allocatable next cycle.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign player_live = |(valid_q & owner_q);
  assign tick        = (tick_cnt_q == TICK_LAST);

  // Round-robin only matters when both sides are eligible; rr_last_alien_q
  // set means the player wins the next contest.
  always_comb begin
    player_elig = req_player && !player_live && (cooldown_q == '0) && any_free;
    alien_elig  = req_alien && any_free;
    win_player  = player_elig && (!alien_elig || rr_last_alien_q);
    win_alien   = alien_elig && (!player_elig || !rr_last_alien_q);
  end

  // Per-slot next state. Allocation takes priority (the slot was free, so a
  // hit or tick cannot apply to it), then hit retire, then tick movement.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((win_player || win_alien) && (free_idx == IW'(i))) begin
        valid_d[i] = 1'b1;
        owner_d[i] = win_player;
        x_d[i]     = win_player ? (x_player + X_OFFSET) : x_alien;
        y_d[i]     = win_player ? PLAYER_Y : y_alien;
      end else if (valid_q[i] && hit_valid && (hit_slot == 3'(i))) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i] && tick) begin
        if (owner_q[i]) begin
          if ({1'b0, y_q[i]} < TOP_LIMIT) valid_d[i] = 1'b0;
          else                             y_d[i] = y_q[i] - STEP11;
        end else begin
          if (({1'b0, y_q[i]} + STEP12) > BOTTOM_LIMIT) valid_d[i] = 1'b0;
          else                                          y_d[i] = y_q[i] + STEP11;
        end
      end
    end
  end

  // State register: slots, cooldown, movement tick, arbitration history and
  // the registered grant / pool_full outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= '0;
      owner_q         <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cooldown_q      <= '0;
      tick_cnt_q      <= '0;
      rr_last_alien_q <= 1'b1;
      grant_player_q  <= 1'b0;
      grant_alien_q   <= 1'b0;
      pool_full_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      if (win_player)              cooldown_q <= COOLDOWN_LOAD;
      else if (cooldown_q != '0)   cooldown_q <= cooldown_q - CW'(1);
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      if (player_elig && alien_elig) rr_last_alien_q <= win_alien;
      grant_player_q <= win_player;
      grant_alien_q  <= win_alien;
      pool_full_q    <= &valid_d;
    end
  end

  assign grant_player = grant_player_q;
  assign grant_alien  = grant_alien_q;
  assign pool_full    = pool_full_q;
  assign player_busy  = player_live || (cooldown_q != '0);
  assign slot_valid   = valid_q;
  assign slot_owner   = owner_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign slot_x_flat[11*g +: 11] = x_q[g];
    assign slot_y_flat[11*g +: 11] = y_q[g];
  end

endmodule

// File: tb/tb_shot_slot_arbiter.sv
// Testbench for shot_slot_arbiter: directed fire/reset checks followed by a
// randomized run compared every cycle against a behavioural model that
// tracks shots as plain integers and derives cooldown and movement ticks
// from edge counts since reset.
module tb_shot_slot_arbiter;
  localparam int NS   = 4;
  localparam int CD   = 20;
  localparam int TD   = 4;
  localparam int STEP = 2;
  localparam int YT   = 10;
  localparam int YB   = 500;
  localparam int PSY  = 40;
  localparam int PXO  = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_player = 1'b0;
  logic [10:0]     x_player = '0;
  logic            req_alien = 1'b0;
  logic [10:0]     x_alien = '0;
  logic [10:0]     y_alien = '0;
  logic            hit_valid = 1'b0;
  logic [2:0]      hit_slot = '0;
  logic            grant_player, grant_alien, player_busy, pool_full;
  logic [NS-1:0]   slot_valid, slot_owner;
  logic [11*NS-1:0] slot_x_flat, slot_y_flat;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_valid [NS];
  int m_owner [NS];
  int m_x [NS];
  int m_y [NS];
  int m_n;
  int m_last_pg;
  bit m_prefer_player;
  bit m_gp, m_ga;

  shot_slot_arbiter #(
    .NUM_SLOTS(NS), .PLAYER_COOLDOWN(CD), .TICK_DIV(TD), .SHOT_STEP(STEP),
    .Y_TOP(YT), .Y_BOTTOM(YB), .PLAYER_SHOT_Y(PSY), .PLAYER_X_OFFSET(PXO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_player(req_player), .x_player(x_player),
    .req_alien(req_alien), .x_alien(x_alien), .y_alien(y_alien),
    .hit_valid(hit_valid), .hit_slot(hit_slot),
    .grant_player(grant_player), .grant_alien(grant_alien),
    .player_busy(player_busy), .pool_full(pool_full),
    .slot_valid(slot_valid), .slot_owner(slot_owner),
    .slot_x_flat(slot_x_flat), .slot_y_flat(slot_y_flat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour. Edge n after reset fires a
  // movement tick when n is a multiple of TD; the player may fire again once
  // more than CD edges have passed since its last grant.
  task automatic modelStep(input bit rst, input bit rp, input int xp, input bit ra,
                           input int xa, input int ya, input bit hv, input int hs);
    int fi;
    bit plive, tick, pel, ael, wp, wa;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_valid[i] = 0; m_owner[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_n = 0;
      m_last_pg = -1000;
      m_prefer_player = 1'b1;
      m_gp = 1'b0;
      m_ga = 1'b0;
    end else begin
      m_n++;
      tick = (m_n % TD) == 0;
      fi = -1;
      plive = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (m_valid[i] == 0 && fi < 0) fi = i;
        if (m_valid[i] != 0 && m_owner[i] != 0) plive = 1'b1;
      end
      pel = rp && !plive && (m_n - m_last_pg > CD) && (fi >= 0);
      ael = ra && (fi >= 0);
      wp = 1'b0;
      wa = 1'b0;
      if (pel && ael) begin
        if (m_prefer_player) wp = 1'b1;
        else                 wa = 1'b1;
        m_prefer_player = !m_prefer_player;
      end else begin
        wp = pel;
        wa = ael;
      end
      for (int i = 0; i < NS; i++) begin
        if ((wp || wa) && i == fi) begin
          // newly allocated below, untouched by hit or tick
        end else if (m_valid[i] != 0 && hv && hs == i) begin
          m_valid[i] = 0;
        end else if (m_valid[i] != 0 && tick) begin
          if (m_owner[i] != 0) begin
            if (m_y[i] < YT + STEP) m_valid[i] = 0;
            else                    m_y[i] -= STEP;
          end else begin
            if (m_y[i] + STEP > YB) m_valid[i] = 0;
            else                    m_y[i] += STEP;
          end
        end
      end
      if (wp) begin
        m_valid[fi] = 1; m_owner[fi] = 1; m_x[fi] = (xp + PXO) % 2048; m_y[fi] = PSY;
        m_last_pg = m_n;
      end
      if (wa) begin
        m_valid[fi] = 1; m_owner[fi] = 0; m_x[fi] = xa; m_y[fi] = ya;
      end
      m_gp = wp;
      m_ga = wa;
    end
  endtask

  task automatic compareAll();
    int ev;
    bit plive, full;
    ev = 0;
    plive = 1'b0;
    full = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i] != 0) begin
        ev |= (1 << i);
        if (m_owner[i] != 0) plive = 1'b1;
        checkOutput($sformatf("owner%0d", i), 64'(slot_owner[i]), 64'(m_owner[i]));
        checkOutput($sformatf("x%0d", i), 64'(slot_x_flat[11*i +: 11]), 64'(m_x[i]));
        checkOutput($sformatf("y%0d", i), 64'(slot_y_flat[11*i +: 11]), 64'(m_y[i]));
      end else begin
        full = 1'b0;
      end
    end
    checkOutput("grant_player", 64'(grant_player), 64'(m_gp));
    checkOutput("grant_alien", 64'(grant_alien), 64'(m_ga));
    checkOutput("slot_valid", 64'(slot_valid), 64'(ev));
    checkOutput("pool_full", 64'(pool_full), 64'(full));
    checkOutput("player_busy", 64'(player_busy), 64'(plive || (m_n - m_last_pg < CD)));
  endtask

  // Drive one cycle of inputs away from the active edge, advance the model,
  // then sample the DUT just after the edge.
  task automatic applyStimulus(input bit rst, input bit rp, input int xp, input bit ra,
                               input int xa, input int ya, input bit hv, input int hs);
    @(negedge clk);
    reset      = rst;
    req_player = rp;
    x_player   = 11'(xp);
    req_alien  = ra;
    x_alien    = 11'(xa);
    y_alien    = 11'(ya);
    hit_valid  = hv;
    hit_slot   = 3'(hs);
    modelStep(rst, rp, xp, ra, xa, ya, hv, hs);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    bit rst, rp, ra, hv;
    int xp, xa, ya, hs;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_valid", 64'(slot_valid), 64'd0);
    checkOutput("rst_owner", 64'(slot_owner), 64'd0);
    checkOutput("rst_x", 64'(slot_x_flat), 64'd0);
    checkOutput("rst_y", 64'(slot_y_flat), 64'd0);
    checkOutput("rst_busy", 64'(player_busy), 64'd0);

    applyStimulus(0, 1, 445, 0, 0, 0, 0, 0);
    checkOutput("fire_grant", 64'(grant_player), 64'd1);
    checkOutput("fire_x", 64'(slot_x_flat[10:0]), 64'd455);
    checkOutput("fire_y", 64'(slot_y_flat[10:0]), 64'(PSY));
    checkOutput("fire_busy", 64'(player_busy), 64'd1);
    applyStimulus(0, 1, 445, 0, 0, 0, 0, 0);
    checkOutput("hold_no_refire", 64'(grant_player), 64'd0);

    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      rp  = 1'($urandom_range(0, 1));
      xp  = int'($urandom_range(0, 2047));
      ra  = ($urandom_range(0, 2) == 0);
      xa  = int'($urandom_range(0, 2047));
      ya  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(490, 500))
                                         : int'($urandom_range(0, 500));
      hv  = ($urandom_range(0, 5) == 0);
      hs  = int'($urandom_range(0, 7));
      applyStimulus(rst, rp, xp, ra, xa, ya, hv, hs);
    end

    applyStimulus(1, 0, 0, 1, 100, 200, 0, 0);
    checkOutput("midrst_valid", 64'(slot_valid), 64'd0);
    checkOutput("midrst_busy", 64'(player_busy), 64'd0);
    applyStimulus(0, 1, 2045, 0, 0, 0, 0, 0);
    checkOutput("post_rst_grant", 64'(grant_player), 64'd1);
    checkOutput("post_rst_xwrap", 64'(slot_x_flat[10:0]), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
